// File: rtl/main_bus_pkg.sv
// main_bus_pkg: shared bus widths and responder FSM state type
package main_bus_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    typedef enum logic [1:0] {IDLE, WAIT, RESP, DONE} resp_state_t;
endpackage

// File: rtl/main_bus_ram_core.sv
// main_bus_ram_core: synchronous single-port RAM, one-cycle registered read.
// Ports: clk_i clock, we_i write enable, re_i read enable, addr_i word address,
//        wdata_i write data, rdata_o read data (holds until the next read).
module main_bus_ram_core
    import main_bus_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**AW];
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/main_bus_responder.sv
// main_bus_responder: four-phase handshake bus responder backed by a local RAM.
// Ports: clock, resetN (async active-low), data (inout, driven only in a read
//        response), address, mem_read/mem_write (level-held strobes),
//        data_ready (acknowledge), proto_err (one-cycle violation pulse).
// Optional: MAIN_BUS_RESP_COUNT_EN adds access_count, a wrapping count of
//        completed responses.
module main_bus_responder
    import main_bus_pkg::*;
#(
    parameter int               ADDR_BITS   = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 16'h0000,
    parameter int               WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              resetN,
    inout  wire  [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] address,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              data_ready,
    output logic              proto_err
`ifdef MAIN_BUS_RESP_COUNT_EN
    ,
    output logic [15:0]       access_count
`endif
);
    resp_state_t          state_q;
    logic                 rd_s_q, wr_s_q;
    logic [ADDR_W-1:0]    addr_s_q;
    logic [DATA_W-1:0]    wdata_s_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rdata;
    logic [3:0]           cnt_q;
    logic                 wr_q, oe_q, arm_q;
    logic                 sel, active, resp_go;

    // All bus inputs pass through one register stage; this stage accounts for
    // the extra cycle between the strobe being sampled and the FSM accepting it.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rd_s_q    <= 1'b0;
            wr_s_q    <= 1'b0;
            addr_s_q  <= '0;
            wdata_s_q <= '0;
        end else begin
            rd_s_q    <= mem_read;
            wr_s_q    <= mem_write;
            addr_s_q  <= address;
            wdata_s_q <= data;
        end
    end

    assign sel     = addr_s_q[ADDR_W-1:ADDR_BITS] == BASE_ADDR[ADDR_W-1:ADDR_BITS];
    assign active  = wr_q ? wr_s_q : rd_s_q;
    assign resp_go = state_q == WAIT && active && cnt_q == 4'd0;

    // arm_q requires both strobes to be seen low in IDLE before the next
    // acceptance, so a held strobe never restarts an access.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            arm_q      <= 1'b1;
            oe_q       <= 1'b0;
            data_ready <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            proto_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rd_s_q && !wr_s_q) begin
                        arm_q <= 1'b1;
                    end else if (sel && arm_q) begin
                        arm_q <= 1'b0;
                        if (rd_s_q && wr_s_q) begin
                            proto_err <= 1'b1;
                        end else begin
                            addr_q  <= addr_s_q[ADDR_BITS-1:0];
                            wdata_q <= wdata_s_q;
                            wr_q    <= wr_s_q;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!active) begin
                        proto_err <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= IDLE;
                    end else if (resp_go) begin
                        data_ready <= 1'b1;
                        oe_q       <= !wr_q;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (!active) begin
                        data_ready <= 1'b0;
                        oe_q       <= 1'b0;
                        state_q    <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end

    // The write lands on the RESP entry edge only; an abort or reset before
    // then leaves the RAM untouched.
    main_bus_ram_core #(.AW(ADDR_BITS)) u_ram (
        .clk_i  (clock),
        .we_i   (resp_go && wr_q),
        .re_i   (state_q == WAIT && !wr_q),
        .addr_i (addr_q),
        .wdata_i(wdata_q),
        .rdata_o(rdata)
    );

    assign data = oe_q ? rdata : 'z;

`ifdef MAIN_BUS_RESP_COUNT_EN
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) access_count <= '0;
        else if (resp_go) access_count <= access_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_main_bus_responder.sv
// tb_main_bus_responder: scoreboard bench for main_bus_responder
module tb_main_bus_responder;
    localparam int WS = 3;
    typedef struct packed {
        logic        rd;
        logic [15:0] d;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] drv = '0;
    logic        drv_en = 1'b0;
    wire  [15:0] data;
    wire         data_ready;
    wire         proto_err;
`ifdef MAIN_BUS_RESP_COUNT_EN
    wire  [15:0] access_count;
`endif

    exp_t q[$];
    int   vec = 0;
    int   err = 0;
    int   pe_cnt = 0;
    int   done_cnt = 0;
    logic dr_prev = 1'b0;

    // Released bus floats high, so a value of FFFF means nobody drives it.
    for (genvar g = 0; g < 16; g++) begin : g_pu
        pullup (data[g]);
    end
    assign data = drv_en ? drv : 'z;

    always #5 clock = ~clock;

    main_bus_responder #(
        .ADDR_BITS  (8),
        .BASE_ADDR  (16'h0000),
        .WAIT_STATES(WS)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .data      (data),
        .address   (address),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .data_ready(data_ready),
        .proto_err (proto_err)
`ifdef MAIN_BUS_RESP_COUNT_EN
        ,
        .access_count(access_count)
`endif
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising data_ready must match the oldest expected response.
    always @(negedge clock) begin
        exp_t e;
        if (proto_err) pe_cnt++;
        if (data_ready && !dr_prev) begin
            vec++;
            done_cnt++;
            if (q.size() == 0) begin
                err++;
                $display("FAIL unexpected_ready: got data_ready=1 expected no response");
            end else begin
                e = q.pop_front();
                if (e.rd && data !== e.d) begin
                    err++;
                    $display("FAIL read_data: got %h expected %h", data, e.d);
                end
            end
        end
        dr_prev <= data_ready;
    end

    task automatic access(input bit rd, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] expd);
        int n = 0;
        int pe0 = pe_cnt;
        @(negedge clock);
        address = a; mem_read = rd; mem_write = !rd; drv = d; drv_en = !rd;
        q.push_back('{rd, expd});
        @(posedge clock);
        while (!data_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 16'(n), 16'(WS + 2));
        address = a ^ 16'h00FF;
        drv = ~d;
        @(negedge clock);
        if (rd) chk("read_hold", data, expd);
        mem_read = 1'b0; mem_write = 1'b0; drv_en = 1'b0;
        n = 0;
        while (data_ready && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("ready_drop", {15'b0, data_ready}, 16'd0);
        chk("release", data, 16'hFFFF);
        chk("no_proto_err", 16'(pe_cnt - pe0), 16'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic miss(input logic [15:0] a, input int cycles);
        logic bad = 1'b0;
        @(negedge clock);
        address = a; mem_read = 1'b1;
        repeat (cycles) begin
            @(negedge clock);
            if (data_ready || data !== 16'hFFFF) bad = 1'b1;
        end
        chk("decode_miss", {15'b0, bad}, 16'd0);
        mem_read = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        int   pe0;
        int   n;
        logic nr;
        repeat (2) @(negedge clock);
        chk("rst_ready", {15'b0, data_ready}, 16'd0);
        chk("rst_proto_err", {15'b0, proto_err}, 16'd0);
        chk("rst_data_z", data, 16'hFFFF);
        resetN = 1'b1;
        repeat (2) @(negedge clock);

        access(1'b0, 16'h0010, 16'hA5C3, 16'h0000);
        access(1'b1, 16'h0010, 16'h0000, 16'hA5C3);
        access(1'b0, 16'h0004, 16'h0BAD, 16'h0000);
        access(1'b0, 16'h0020, 16'h7E57, 16'h0000);
        access(1'b0, 16'h00FF, 16'h1357, 16'h0000);
        access(1'b0, 16'h0000, 16'h2468, 16'h0000);
        access(1'b0, 16'h0001, 16'h5A5A, 16'h0000);
        access(1'b1, 16'h00FF, 16'h0000, 16'h1357);
        access(1'b1, 16'h0000, 16'h0000, 16'h2468);

        // Both strobes together: one proto_err pulse, no response.
        pe0 = pe_cnt; nr = 1'b0;
        @(negedge clock);
        address = 16'h0004; mem_read = 1'b1; mem_write = 1'b1; drv = 16'hFACE; drv_en = 1'b1;
        repeat (6) begin
            @(negedge clock);
            nr |= data_ready;
        end
        mem_read = 1'b0; mem_write = 1'b0; drv_en = 1'b0;
        repeat (2) @(negedge clock);
        chk("both_proto_err", 16'(pe_cnt - pe0), 16'd1);
        chk("both_no_ready", {15'b0, nr}, 16'd0);
        access(1'b1, 16'h0004, 16'h0000, 16'h0BAD);

        // Write dropped during WAIT: abort, no commit.
        pe0 = pe_cnt; nr = 1'b0;
        @(negedge clock);
        address = 16'h0020; mem_write = 1'b1; drv = 16'h1234; drv_en = 1'b1;
        @(negedge clock);
        mem_write = 1'b0; drv_en = 1'b0;
        repeat (12) begin
            @(negedge clock);
            nr |= data_ready;
        end
        chk("abort_no_ready", {15'b0, nr}, 16'd0);
        chk("abort_proto_err", 16'(pe_cnt - pe0), 16'd1);
        access(1'b1, 16'h0020, 16'h0000, 16'h7E57);

        miss(16'h0210, 20);
        miss(16'h0100, 10);

        // Strobe low for a single sample across RESP/DONE: no second access.
        @(negedge clock);
        address = 16'h0001; mem_read = 1'b1;
        q.push_back('{1'b1, 16'h5A5A});
        n = 0;
        while (!data_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        mem_read = 1'b0;
        @(negedge clock);
        mem_read = 1'b1;
        nr = 1'b0;
        repeat (15) begin
            @(negedge clock);
            nr |= data_ready;
        end
        chk("no_reaccept", {15'b0, nr}, 16'd0);
        mem_read = 1'b0;
        repeat (3) @(negedge clock);
        access(1'b1, 16'h0001, 16'h0000, 16'h5A5A);

        // Reset asserted while responding to a read.
        @(negedge clock);
        address = 16'h0010; mem_read = 1'b1;
        q.push_back('{1'b1, 16'hA5C3});
        n = 0;
        while (!data_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        chk("pre_rst_ready", {15'b0, data_ready}, 16'd1);
        #2 resetN = 1'b0;
        done_cnt = 0;
        #1;
        chk("rst_mid_ready", {15'b0, data_ready}, 16'd0);
        chk("rst_mid_data_z", data, 16'hFFFF);
        @(negedge clock);
        mem_read = 1'b0;
        @(negedge clock);
        resetN = 1'b1;
        repeat (2) @(negedge clock);
        access(1'b1, 16'h0010, 16'h0000, 16'hA5C3);
        access(1'b1, 16'h0020, 16'h0000, 16'h7E57);

        chk("pending", 16'(q.size()), 16'd0);
`ifdef MAIN_BUS_RESP_COUNT_EN
        chk("access_count", access_count, 16'(done_cnt));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
